regfile_scan_checker: RTL and testbench

- Synthesizable on-chip test harness that sits between the processor and its register file. It runs the CPU for a programmed number of cycles, then takes over the regfile's A read port. It scans every register, compares each one against an expected-value memory, and reports pass/fail, error count and per-mismatch detail.
- This is the parametrised hardware successor of the simulation-only register-checking flow. It is generalised in register count, data width, cycle budget and compare mode, so FPGA builds can self-check without a simulator.

---
 rtl/regfile_scan_checker_pkg.sv | 30 +++
 rtl/regfile_scan_checker_scan_compare_stage.sv | 90 +++++++++
 rtl/regfile_scan_checker.sv | 218 +++++++++++++++++++++
 tb/tb_regfile_scan_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scan_checker_pkg.sv
// Shared definitions for the register-file scan checker.
//   state_e  : controller state encoding (IDLE -> RUN -> SCAN -> DRAIN -> DONE)
//   sat_inc  : saturating increment for counters up to 32 bits wide
package regfile_scan_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Callers zero-extend their counter to 32 bits and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    if (width >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (val >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/regfile_scan_checker_scan_compare_stage.sv
// Scan compare stage: registers the regfile read (act/idx) on the issue edge
// and compares it one cycle later against the expected-memory data, which
// arrives with the same one-cycle latency.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   issue_i            : a register is being read this cycle
//   idx_i, act_i       : index being issued and its regfile port-A data
//   cmp_en_i           : compare window open (SCAN or DRAIN)
//   exp_data_i         : expected value for the registered index
//   mismatch_o         : a counted mismatch this cycle
//   mis_valid_o/reg/exp/act : mismatch detail, zero when no mismatch
module regfile_scan_checker_scan_compare_stage
  import regfile_scan_checker_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int SKIP_R0 = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] act_i,
  input  logic              cmp_en_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              mismatch_o,
  output logic              mis_valid_o,
  output logic [REG_AW-1:0] mis_reg_o,
  output logic [DATA_W-1:0] mis_exp_o,
  output logic [DATA_W-1:0] mis_act_o
);

  logic              vld_q, vld_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] act_q, act_d;
  logic              skip_s;
  logic              mismatch_s;

  // Next-state for the issue pipeline: capture only when a register is issued.
  always_comb begin
    vld_d = issue_i;
    if (issue_i) begin
      idx_d = idx_i;
      act_d = act_i;
    end else begin
      idx_d = idx_q;
      act_d = act_q;
    end
  end

  // Issue pipeline registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      idx_q <= {REG_AW{1'b0}};
      act_q <= {DATA_W{1'b0}};
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
      act_q <= act_d;
    end
  end

  // Compare; reset in the same cycle discards the in-flight result.
  always_comb begin
    skip_s = (SKIP_R0 != 0) && (idx_q == {REG_AW{1'b0}});
    if (vld_q && cmp_en_i && !rst_i && !skip_s && (exp_data_i != act_q)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Mismatch detail is driven only while the pulse is high.
  always_comb begin
    if (mismatch_s) begin
      mis_reg_o = idx_q;
      mis_exp_o = exp_data_i;
      mis_act_o = act_q;
    end else begin
      mis_reg_o = {REG_AW{1'b0}};
      mis_exp_o = {DATA_W{1'b0}};
      mis_act_o = {DATA_W{1'b0}};
    end
  end

  assign mismatch_o  = mismatch_s;
  assign mis_valid_o = mismatch_s;

endmodule

// File: rtl/regfile_scan_checker.sv
// On-chip register-file checker. Lets the CPU run for num_cycles_i cycles,
// then takes over regfile read port A, scans every register, and compares it
// against an expected-value memory with a one-cycle read latency.
// Ports:
//   clock_i, reset_i          : clock, synchronous active-high reset
//   start_i, num_cycles_i     : start pulse (IDLE/DONE only) and run budget
//   cpu_rwe_i, cpu_rd_i       : CPU write observation for write_count_o
//   cpu_rs1_i / rf_rs1_o      : CPU port-A address / muxed regfile address
//   rf_data_a_i               : regfile port-A read data (combinational)
//   exp_addr_o, exp_data_i    : expected-memory address / data (1-cycle latency)
//   cpu_hold_o, test_mode_o   : CPU held outside RUN; checker owns port A
//   done_o, pass_o            : run complete / complete with zero errors
//   error_count_o, write_count_o : saturating counters
//   mis_valid_o, mis_reg_o, mis_exp_o, mis_act_o : per-mismatch detail
module regfile_scan_checker
  import regfile_scan_checker_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int CYC_W       = 20,
  parameter int ERR_W       = 8,
  parameter int SKIP_R0     = 1,
  parameter int STOP_ON_ERR = 0,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [CYC_W-1:0]  num_cycles_i,
  input  logic              cpu_rwe_i,
  input  logic [REG_AW-1:0] cpu_rd_i,
  input  logic [REG_AW-1:0] cpu_rs1_i,
  output logic [REG_AW-1:0] rf_rs1_o,
  input  logic [DATA_W-1:0] rf_data_a_i,
  output logic [REG_AW-1:0] exp_addr_o,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              cpu_hold_o,
  output logic              test_mode_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ERR_W-1:0]  error_count_o,
  output logic [CYC_W-1:0]  write_count_o,
  output logic              mis_valid_o,
  output logic [REG_AW-1:0] mis_reg_o,
  output logic [DATA_W-1:0] mis_exp_o,
  output logic [DATA_W-1:0] mis_act_o
);

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [REG_AW-1:0] scan_q, scan_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CYC_W-1:0]  wc_q, wc_d;

  logic start_ok_s;
  logic last_s;
  logic mismatch_s;
  logic abort_s;
  logic issue_s;
  logic cmp_en_s;
  logic cpu_hold_s;
  logic test_mode_s;
  logic done_s;

  assign start_ok_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_s     = (scan_q == REG_AW'(NUM_REGS - 1));
  assign abort_s    = (STOP_ON_ERR != 0) && mismatch_s;
  assign issue_s    = (state_q == ST_SCAN);
  assign cmp_en_s   = (state_q == ST_SCAN) || (state_q == ST_DRAIN);

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero budget skips RUN entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = (num_cycles_i == {CYC_W{1'b0}}) ? ST_SCAN : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (cyc_q <= CYC_W'(1)) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SCAN: begin
        if (abort_s) begin
          state_d = ST_DONE;
        end else if (last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    cpu_hold_s  = 1'b1;
    test_mode_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_hold_s = 1'b1;
      end
      ST_RUN: begin
        cpu_hold_s = 1'b0;
      end
      ST_SCAN, ST_DRAIN: begin
        test_mode_s = 1'b1;
      end
      ST_DONE: begin
        test_mode_s = 1'b1;
        done_s      = 1'b1;
      end
      default: begin
        cpu_hold_s  = 1'b1;
        test_mode_s = 1'b0;
        done_s      = 1'b0;
      end
    endcase
  end

  // Counter next-state: an accepted start clears all results.
  always_comb begin
    cyc_d  = cyc_q;
    scan_d = scan_q;
    err_d  = err_q;
    wc_d   = wc_q;
    if (start_ok_s) begin
      cyc_d  = num_cycles_i;
      scan_d = {REG_AW{1'b0}};
      err_d  = {ERR_W{1'b0}};
      wc_d   = {CYC_W{1'b0}};
    end else begin
      if (state_q == ST_RUN) begin
        cyc_d = cyc_q - CYC_W'(1);
      end else begin
        cyc_d = cyc_q;
      end
      // The index parks on the last register; DRAIN only finishes its compare.
      if ((state_q == ST_SCAN) && !last_s) begin
        scan_d = scan_q + REG_AW'(1);
      end else begin
        scan_d = scan_q;
      end
      if (mismatch_s) begin
        err_d = ERR_W'(sat_inc(32'(err_q), ERR_W));
      end else begin
        err_d = err_q;
      end
      if ((state_q == ST_RUN) && cpu_rwe_i && (cpu_rd_i != {REG_AW{1'b0}})) begin
        wc_d = CYC_W'(sat_inc(32'(wc_q), CYC_W));
      end else begin
        wc_d = wc_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cyc_q  <= {CYC_W{1'b0}};
      scan_q <= {REG_AW{1'b0}};
      err_q  <= {ERR_W{1'b0}};
      wc_q   <= {CYC_W{1'b0}};
    end else begin
      cyc_q  <= cyc_d;
      scan_q <= scan_d;
      err_q  <= err_d;
      wc_q   <= wc_d;
    end
  end

  regfile_scan_checker_scan_compare_stage #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .SKIP_R0 (SKIP_R0)
  ) u_cmp (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .issue_i     (issue_s),
    .idx_i       (scan_q),
    .act_i       (rf_data_a_i),
    .cmp_en_i    (cmp_en_s),
    .exp_data_i  (exp_data_i),
    .mismatch_o  (mismatch_s),
    .mis_valid_o (mis_valid_o),
    .mis_reg_o   (mis_reg_o),
    .mis_exp_o   (mis_exp_o),
    .mis_act_o   (mis_act_o)
  );

  assign rf_rs1_o      = test_mode_s ? scan_q : cpu_rs1_i;
  assign exp_addr_o    = scan_q;
  assign cpu_hold_o    = cpu_hold_s;
  assign test_mode_o   = test_mode_s;
  assign done_o        = done_s;
  assign pass_o        = done_s && (err_q == {ERR_W{1'b0}});
  assign error_count_o = err_q;
  assign write_count_o = wc_q;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Bench for regfile_scan_checker. Four instances share one regfile model and
// one expected memory:
//   0: defaults   1: STOP_ON_ERR=1   2: SKIP_R0=0   3: ERR_W=2
module tb_regfile_scan_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] num_cycles;
  logic        cpu_rwe;
  logic [4:0]  cpu_rd;
  logic [4:0]  cpu_rs1;

  logic [31:0] rf [32];
  logic [31:0] em [32];

  logic [3:0]       hold, tm, dn, ps, mv;
  logic [3:0][7:0]  err;
  logic [3:0][19:0] wc;
  logic [3:0][4:0]  ra, ea, mreg;
  logic [3:0][31:0] mexp, mact;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    localparam int EW = (g == 3) ? 2 : 8;
    localparam int SK = (g == 2) ? 0 : 1;
    localparam int ST = (g == 1) ? 1 : 0;
    logic [EW-1:0] ec;
    logic [31:0]   rda;
    logic [31:0]   ed;

    assign rda = rf[ra[g]];
    // Expected memory: synchronous read, one-cycle latency.
    always_ff @(posedge clk) ed <= em[ea[g]];

    regfile_scan_checker #(
      .DATA_W(32), .NUM_REGS(32), .CYC_W(20), .ERR_W(EW),
      .SKIP_R0(SK), .STOP_ON_ERR(ST)
    ) u_dut (
      .clock_i(clk), .reset_i(rst), .start_i(start), .num_cycles_i(num_cycles),
      .cpu_rwe_i(cpu_rwe), .cpu_rd_i(cpu_rd), .cpu_rs1_i(cpu_rs1),
      .rf_rs1_o(ra[g]), .rf_data_a_i(rda), .exp_addr_o(ea[g]), .exp_data_i(ed),
      .cpu_hold_o(hold[g]), .test_mode_o(tm[g]), .done_o(dn[g]), .pass_o(ps[g]),
      .error_count_o(ec), .write_count_o(wc[g]), .mis_valid_o(mv[g]),
      .mis_reg_o(mreg[g]), .mis_exp_o(mexp[g]), .mis_act_o(mact[g])
    );
    assign err[g] = 8'(ec);
  end

  typedef struct {
    int inst; int r; int e; int a;
  } mis_t;
  mis_t mq[$];

  // Record every mismatch pulse from every instance.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mv[k]) mq.push_back('{k, int'(mreg[k]), int'(mexp[k]), int'(mact[k])});
    end
  end

  typedef struct {
    int num; int pat; bit wr; bit rd0w; int gap_reg; int e_wc;
  } row_t;
  typedef struct {
    int row; int inst; int e_err; bit e_pass; int np; int preg; int pexp; int pact;
  } exp_t;
  row_t rows[5];
  exp_t exps[20];

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // 0 match, 1 r7/r31 wrong, 2 r0 expected 5, 3 every r1..r31 expected off by one
  task automatic set_pattern(input int p);
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i * 3);
      em[i] = 32'(i * 3);
    end
    case (p)
      1: begin rf[7] = 32'd20; rf[31] = 32'd0; end
      2: em[0] = 32'd5;
      3: for (int i = 1; i < 32; i++) em[i] = 32'(i * 3 + 1);
      default: ;
    endcase
  endtask

  initial begin
    int run_cnt, scan_cnt, t_iss, t_done, np, first, second, c;
    bit ok;

    //           num pat wr rd0w gap wc
    rows[0] = '{5, 0, 1'b1, 1'b0, -1, 1};
    rows[1] = '{3, 1, 1'b0, 1'b1,  7, 0};
    rows[2] = '{0, 2, 1'b0, 1'b0, -1, 0};
    rows[3] = '{2, 3, 1'b0, 1'b0,  1, 0};
    rows[4] = '{1, 0, 1'b0, 1'b0, -1, 0};
    //          row inst err pass np reg exp act
    exps[0]  = '{0, 0, 0, 1'b1, 0, 0, 0, 0};
    exps[1]  = '{0, 1, 0, 1'b1, 0, 0, 0, 0};
    exps[2]  = '{0, 2, 0, 1'b1, 0, 0, 0, 0};
    exps[3]  = '{0, 3, 0, 1'b1, 0, 0, 0, 0};
    exps[4]  = '{1, 0, 2, 1'b0, 2, 7, 21, 20};
    exps[5]  = '{1, 1, 1, 1'b0, 1, 7, 21, 20};
    exps[6]  = '{1, 2, 2, 1'b0, 2, 7, 21, 20};
    exps[7]  = '{1, 3, 2, 1'b0, 2, 7, 21, 20};
    exps[8]  = '{2, 0, 0, 1'b1, 0, 0, 0, 0};
    exps[9]  = '{2, 1, 0, 1'b1, 0, 0, 0, 0};
    exps[10] = '{2, 2, 1, 1'b0, 1, 0, 5, 0};
    exps[11] = '{2, 3, 0, 1'b1, 0, 0, 0, 0};
    exps[12] = '{3, 0, 31, 1'b0, 31, 1, 4, 3};
    exps[13] = '{3, 1, 1, 1'b0, 1, 1, 4, 3};
    exps[14] = '{3, 2, 31, 1'b0, 31, 1, 4, 3};
    exps[15] = '{3, 3, 3, 1'b0, 31, 1, 4, 3};
    exps[16] = '{4, 0, 0, 1'b1, 0, 0, 0, 0};
    exps[17] = '{4, 1, 0, 1'b1, 0, 0, 0, 0};
    exps[18] = '{4, 2, 0, 1'b1, 0, 0, 0, 0};
    exps[19] = '{4, 3, 0, 1'b1, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; num_cycles = 20'd0;
    cpu_rwe = 1'b0; cpu_rd = 5'd0; cpu_rs1 = 5'd3;
    set_pattern(0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("reset cpu_hold", hold[0], 1);
    chk("reset test_mode", tm[0], 0);
    chk("reset done", dn[0], 0);
    chk("reset pass", ps[0], 0);
    chk("reset error_count", err[0], 0);
    chk("reset write_count", wc[0], 0);
    chk("reset mis_valid", mv[0], 0);
    chk("reset exp_addr", ea[0], 0);
    chk("reset rf_rs1 follows cpu_rs1", ra[0], 3);

    for (int r = 0; r < 5; r++) begin
      set_pattern(rows[r].pat);
      mq.delete();
      num_cycles = 20'(rows[r].num);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("first cycle after start is RUN", !hold[0], rows[r].num != 0);
      run_cnt = 0; scan_cnt = 0; t_iss = -1; t_done = -1; ok = 1'b0;
      for (int cy = 1; cy <= 200; cy++) begin
        if (!hold[0]) run_cnt++;
        if (tm[0] && !dn[0]) scan_cnt++;
        if (tm[1] && !dn[1] && (int'(ea[1]) == rows[r].gap_reg) && t_iss < 0) t_iss = cy;
        if (dn[1] && t_done < 0) t_done = cy;
        // The regfile model already holds the value a CPU write would store.
        if (!hold[0]) begin
          if (rows[r].wr && run_cnt == 2) begin
            cpu_rwe = 1'b1; cpu_rd = 5'd4;
          end else begin
            cpu_rwe = rows[r].rd0w; cpu_rd = 5'd0;
          end
        end else begin
          cpu_rwe = 1'b1; cpu_rd = 5'd9;
        end
        if (&dn) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      cpu_rwe = 1'b0;
      chk("run reached DONE in budget", ok, 1);
      chk("RUN length", run_cnt, rows[r].num);
      chk("SCAN+DRAIN length", scan_cnt, 33);
      if (rows[r].gap_reg >= 0) chk("stop-on-error DONE gap", t_done - t_iss, 2);
      for (int e = 0; e < 20; e++) begin
        if (exps[e].row == r) begin
          chk("error_count", err[exps[e].inst], exps[e].e_err);
          chk("pass", ps[exps[e].inst], exps[e].e_pass);
          chk("write_count", wc[exps[e].inst], rows[r].e_wc);
          np = 0; first = -1; second = -1;
          for (int q = 0; q < mq.size(); q++) begin
            if (mq[q].inst == exps[e].inst) begin
              if (np == 0) first = q;
              if (np == 1) second = q;
              np++;
            end
          end
          chk("mis_valid pulse count", np, exps[e].np);
          if (first >= 0) begin
            chk("first mis_reg", mq[first].r, exps[e].preg);
            chk("first mis_exp", mq[first].e, exps[e].pexp);
            chk("first mis_act", mq[first].a, exps[e].pact);
          end
          if (r == 1 && exps[e].inst == 0 && second >= 0) begin
            chk("second mis_reg", mq[second].r, 31);
            chk("second mis_exp", mq[second].e, 93);
            chk("second mis_act", mq[second].a, 0);
          end
        end
      end
    end

    // Zero budget, ignored mid-scan start, reset during SCAN.
    set_pattern(3);
    num_cycles = 20'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("num0 enters SCAN test_mode", tm[0], 1);
    chk("num0 enters SCAN not done", dn[0], 0);
    chk("num0 first scan index", ea[0], 0);
    chk("rf_rs1 driven by scan index", ra[0], 0);
    c = 0;
    while (ea[0] != 5'd5 && c < 40) begin tick(); c++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid-scan start ignored index", ea[0], 6);
    chk("mid-scan start ignored hold", hold[0], 1);
    chk("mid-scan start ignored done", dn[0], 0);
    c = 0;
    while (ea[0] != 5'd10 && c < 40) begin tick(); c++; end
    chk("compare in flight before reset", mv[0], 1);
    rst = 1'b1;
    #1;
    chk("no mis_valid in reset cycle u0", mv[0], 0);
    chk("no mis_valid in reset cycle u2", mv[2], 0);
    tick();
    rst = 1'b0;
    chk("after reset test_mode", tm[0], 0);
    chk("after reset cpu_hold", hold[0], 1);
    chk("after reset done", dn[0], 0);
    chk("after reset pass", ps[0], 0);
    chk("after reset error_count", err[0], 0);
    chk("after reset error_count u2", err[2], 0);
    chk("after reset write_count", wc[0], 0);
    chk("after reset mis_valid", mv[0], 0);
    chk("after reset exp_addr", ea[0], 0);
    cpu_rs1 = 5'd17;
    #1;
    chk("rf_rs1 follows cpu_rs1 in IDLE", ra[0], 17);
    tick();
    chk("no late mis_valid after reset", mv[0], 0);
    chk("error_count still 0", err[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
